// File: rtl/fft_result_reader_pkg.sv
// Shared types for the FFT result readout: default geometry, bank encoding, FSM states
// and the bit-reverse address helper.
package fft_result_reader_pkg;

   localparam int unsigned FFT_N = 8;
   localparam int unsigned FFT_I = 4;
   localparam int unsigned FFT_F = 4;

   typedef enum logic {
      BankRam1 = 1'b0,
      BankRam2 = 1'b1
   } bank_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } rd_state_e;

   // Reverses the low `width` bits of v; upper bits come back zero.
   function automatic logic [15:0] bit_rev(logic [15:0] v, int unsigned width);
      logic [15:0] r;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (i < width) r[i] = v[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_result_reader_if.sv
// Bus between the result reader, the result RAMs and the downstream sample consumer.
interface fft_result_reader_if #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 8
);
   localparam int unsigned AW = $clog2(N);

   logic          i_start;
   logic          i_bank;
   logic          o_bank;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [W-1:0]  i_rd_re;
   logic [W-1:0]  i_rd_im;
   logic          o_valid;
   logic          i_ready;
   logic [W-1:0]  o_data_re;
   logic [W-1:0]  o_data_im;
   logic [AW-1:0] o_idx;
   logic          o_last;
   logic          o_busy;
   logic          o_done;

   modport master (
      input  i_start, i_bank, i_rd_re, i_rd_im, i_ready,
      output o_bank, o_rd_en, o_rd_addr, o_valid, o_data_re, o_data_im, o_idx, o_last,
             o_busy, o_done
   );

   modport slave (
      output i_start, i_bank, i_rd_re, i_rd_im, i_ready,
      input  o_bank, o_rd_en, o_rd_addr, o_valid, o_data_re, o_data_im, o_idx, o_last,
             o_busy, o_done
   );

endinterface

// File: rtl/fft_result_reader_skid.sv
// Two-entry valid/ready skid buffer; head entry drives the output registers directly.
module fft_result_reader_skid #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0] head_q, tail_q;
   logic [1:0]       occ_q;
   logic             pop;

   assign valid     = (occ_q != 2'd0);
   assign pop       = valid & ready;
   assign data      = head_q;
   assign occupancy = occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) head_q <= push_data;
               else               tail_q <= push_data;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind whatever remains.
               if (occ_q == 2'd1) begin
                  head_q <= push_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fft_result_reader.sv
// Streams N complex FFT results from the selected result RAM bank onto a valid/ready port.
// Define FFT_RD_BITREV_EN to read the RAM in bit-reversed address order.
module fft_result_reader
   import fft_result_reader_pkg::*;
#(
   parameter int unsigned N = FFT_N,
   parameter int unsigned I = FFT_I,
   parameter int unsigned F = FFT_F
) (
   input logic               clk,
   input logic               rst,
   fft_result_reader_if.master bus
);

   localparam int unsigned W  = I + F;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] LastCnt = CW'(N - 1);

   rd_state_e      state_q, state_d;
   bank_e          bank_q;
   logic [CW-1:0]  issue_q, out_q;
   logic           in_flight_q;
   logic           rd_en, start_acc, pop, skid_valid;
   logic [1:0]     occ;
   logic [2:0]     eff_fill;
   logic [2*W-1:0] skid_data;

   assign pop       = skid_valid & bus.i_ready;
   assign start_acc = (state_q == StIdle) & bus.i_start;
   // A beat leaving this cycle frees its slot in time for the read issued now.
   assign eff_fill  = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         StIdle:  if (bus.i_start) state_d = StRead;
         StRead: begin
            rd_en = (eff_fill < 3'd2);
            if (rd_en && (issue_q == LastCnt)) state_d = StDrain;
         end
         StDrain: if (pop && (out_q == LastCnt)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bank_q      <= BankRam1;
         issue_q     <= '0;
         out_q       <= '0;
         in_flight_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_flight_q <= rd_en;
         if (start_acc) begin
            bank_q  <= bank_e'(bus.i_bank);
            issue_q <= '0;
            out_q   <= '0;
         end else begin
            if (rd_en) issue_q <= issue_q + CW'(1);
            if (pop)   out_q   <= out_q + CW'(1);
         end
      end
   end

   fft_result_reader_skid #(
      .WIDTH(2 * W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (in_flight_q),
      .push_data ({bus.i_rd_re, bus.i_rd_im}),
      .ready     (bus.i_ready),
      .valid     (skid_valid),
      .data      (skid_data),
      .occupancy (occ)
   );

`ifdef FFT_RD_BITREV_EN
   assign bus.o_rd_addr = AW'(bit_rev(16'(issue_q[AW-1:0]), AW));
`else
   assign bus.o_rd_addr = issue_q[AW-1:0];
`endif

   assign bus.o_rd_en     = rd_en;
   assign bus.o_bank      = bank_q;
   assign bus.o_valid     = skid_valid;
   assign bus.o_data_re   = skid_data[2*W-1:W];
   assign bus.o_data_im   = skid_data[W-1:0];
   assign bus.o_idx       = out_q[AW-1:0];
   assign bus.o_last      = skid_valid & (out_q == LastCnt);
   assign bus.o_busy      = (state_q != StIdle);
   assign bus.o_done      = (state_q == StDone);

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader: scenario table plus reset-abort sequence,
// checked against an expected beat list built from the RAM contents and the address map.
module tb_fft_result_reader;

   localparam int unsigned N  = 8;
   localparam int unsigned I  = 4;
   localparam int unsigned F  = 4;
   localparam int unsigned W  = I + F;
   localparam int unsigned AW = $clog2(N);

   typedef struct {
      int mode;       // 0 ready high, 1 toggling, 2 random, 3 stalled 20 cycles
      bit bank;
      bit rand_data;
      bit toggle;     // flip i_bank every cycle mid-run
      bit restart;    // pulse i_start while busy
      int exp_first;  // expected first o_valid cycle, -1 = don't care
      int exp_done;   // expected o_done cycle, -1 = don't care
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nerr = 0;

   logic [W-1:0] mem_re[2][N];
   logic [W-1:0] mem_im[2][N];

   fft_result_reader_if #(.N(N), .W(W)) bus ();

   fft_result_reader #(.N(N), .I(I), .F(F)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Result RAM pair with one cycle of registered read latency.
   always @(posedge clk) begin
      if (bus.o_rd_en) begin
         bus.i_rd_re <= mem_re[bus.o_bank][bus.o_rd_addr];
         bus.i_rd_im <= mem_im[bus.o_bank][bus.o_rd_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int fref(int k);
      int r;
      r = k;
`ifdef FFT_RD_BITREV_EN
      r = 0;
      for (int b = 0; b < int'(AW); b++) begin
         if (((k >> b) & 1) != 0) r |= 1 << (int'(AW) - 1 - b);
      end
`endif
      return r;
   endfunction

   task automatic fill_mem(input bit bank, input bit rand_data);
      for (int k = 0; k < int'(N); k++) begin
         for (int b = 0; b < 2; b++) begin
            mem_re[b][k] = W'($urandom);
            mem_im[b][k] = W'($urandom);
         end
         if (!rand_data) begin
            mem_re[bank][k] = W'(k);
            mem_im[bank][k] = W'(-k);
         end
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.o_valid), 0);
      chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 0);
      chk({tag, "_busy"},  32'(bus.o_busy), 0);
      chk({tag, "_done"},  32'(bus.o_done), 0);
      chk({tag, "_bank"},  32'(bus.o_bank), 0);
      chk({tag, "_idx"},   32'(bus.o_idx), 0);
      chk({tag, "_last"},  32'(bus.o_last), 0);
      chk({tag, "_data"},  32'({bus.o_data_re, bus.o_data_im}), 0);
   endtask

   task automatic run_case(input vec_t v, input int id);
      int           beats, issued, first_valid;
      bit           done_seen, prev_stall;
      logic [W-1:0] prev_re, prev_im;
      logic [W-1:0] exp_re[N], exp_im[N];

      fill_mem(v.bank, v.rand_data);
      for (int k = 0; k < int'(N); k++) begin
         exp_re[k] = mem_re[v.bank][fref(k)];
         exp_im[k] = mem_im[v.bank][fref(k)];
      end
      beats = 0; issued = 0; first_valid = -1; done_seen = 0; prev_stall = 0;
      prev_re = '0; prev_im = '0;

      @(negedge clk);
      bus.i_bank  = v.bank;
      bus.i_start = 1'b1;
      bus.i_ready = (v.mode == 0);
      @(posedge clk);
      #1 bus.i_start = 1'b0;

      for (int rel = 1; rel <= 300 && !done_seen; rel++) begin
         @(negedge clk);
         case (v.mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = (rel % 2 == 1);
            2:       bus.i_ready = ($urandom_range(0, 3) != 0);
            default: bus.i_ready = (rel > 20);
         endcase
         bus.i_start = v.restart && (rel == 4);
         if (v.toggle) bus.i_bank = ~bus.i_bank;
         #1;
         chk("bank_held", 32'(bus.o_bank), 32'(v.bank));
         chk("busy", 32'(bus.o_busy), 1);
         if (bus.o_rd_en) begin
            chk("rd_addr", 32'(bus.o_rd_addr), 32'(fref(issued)));
            chk("rd_count", 32'(issued < int'(N)), 1);
            issued++;
         end
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.o_valid), 1);
            chk("stall_data", 32'({bus.o_data_re, bus.o_data_im}), 32'({prev_re, prev_im}));
         end
         if (bus.o_valid && first_valid < 0) first_valid = rel;
         if (bus.o_valid && bus.i_ready) begin
            if (beats < int'(N)) begin
               chk("beat_re", 32'(bus.o_data_re), 32'(exp_re[beats]));
               chk("beat_im", 32'(bus.o_data_im), 32'(exp_im[beats]));
               chk("beat_idx", 32'(bus.o_idx), 32'(beats));
            end
            chk("beat_last", 32'(bus.o_last), 32'(beats == int'(N) - 1));
            beats++;
         end else if (bus.o_valid) begin
            chk("last_stall", 32'(bus.o_last), 32'(beats == int'(N) - 1));
         end
         chk("outstanding", 32'(issued - beats <= 2), 1);
         if (v.mode == 3 && rel == 20) begin
            chk("stall_issued", 32'(issued), 2);
            chk("stall_head_valid", 32'(bus.o_valid), 1);
            chk("stall_head_re", 32'(bus.o_data_re), 32'(exp_re[0]));
         end
         if (bus.o_done) begin
            done_seen = 1;
            chk("done_beats", 32'(beats), 32'(N));
            chk("done_valid", 32'(bus.o_valid), 0);
            if (v.exp_done > 0) chk("done_cycle", 32'(rel), 32'(v.exp_done));
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_re    = bus.o_data_re;
         prev_im    = bus.o_data_im;
      end
      chk($sformatf("case%0d_finished", id), 32'(done_seen), 1);
      if (v.exp_first > 0) chk("first_valid", 32'(first_valid), 32'(v.exp_first));

      @(negedge clk);
      bus.i_start = 1'b0;
      #1;
      chk("post_done", 32'(bus.o_done), 0);
      chk("post_busy", 32'(bus.o_busy), 0);
      chk("post_valid", 32'(bus.o_valid), 0);
   endtask

   task automatic run_reset_abort();
      int  beats;
      bit  got_done;
      fill_mem(1'b1, 1'b0);
      beats = 0;
      @(negedge clk);
      bus.i_bank  = 1'b1;
      bus.i_start = 1'b1;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_start = 1'b0;
      for (int c = 0; c < 50 && beats < 4; c++) begin
         @(negedge clk);
         #1;
         if (bus.o_valid && bus.i_ready) beats++;
      end
      chk("abort_reached_beat3", 32'(beats), 4);
      @(negedge clk);
      rst = 1'b1;
      #1 check_idle_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      got_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (bus.o_done || bus.o_busy || bus.o_valid) got_done = 1;
      end
      chk("abort_quiet", 32'(got_done), 0);
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{mode: 0, bank: 0, rand_data: 0, toggle: 0, restart: 0,
                 exp_first: 3, exp_done: N + 3};
      tbl[1] = '{mode: 1, bank: 0, rand_data: 0, toggle: 0, restart: 0,
                 exp_first: 3, exp_done: -1};
      tbl[2] = '{mode: 0, bank: 1, rand_data: 0, toggle: 1, restart: 1,
                 exp_first: 3, exp_done: N + 3};
      tbl[3] = '{mode: 3, bank: 0, rand_data: 0, toggle: 0, restart: 0,
                 exp_first: 3, exp_done: -1};
      for (int i = 4; i < 8; i++) begin
         tbl[i] = '{mode: 2, bank: 1'($urandom), rand_data: 1, toggle: 0, restart: 0,
                    exp_first: -1, exp_done: -1};
      end

      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_bank  = 1'b0;
      bus.i_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_idle_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_case(tbl[i], i);

      run_reset_abort();
      run_case(tbl[0], 8);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
